// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: registered one-hot grant, round-robin fairness, owner lock and
// bounded-hold preemption. Define MEMARB_FIXED_PRIO_EN for lowest-index-wins priority.
module mem_port_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [32*NREQ-1:0]   req_address,
    input  logic [32*NREQ-1:0]   req_offset,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [3*NREQ-1:0]    req_mode,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_offset,
    output logic [31:0]          mem_data,
    output logic [2:0]           mem_mode,
    output logic                 busy
);
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LIMIT = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("mem_port_arbiter: NREQ must be in the range 2..8");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [NREQ-1:0] others;
    logic [NREQ-1:0] win;
    logic            owner_req;
    logic            owner_lock;
    logic            preempt_ok;

    // The owner is never a candidate, so one arbiter serves idle grant, handoff and preemption.
    assign others     = req & ~gnt_reg;
    assign owner_req  = |(req & gnt_reg);
    assign owner_lock = |(lock & gnt_reg);
    assign preempt_ok = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT) && !owner_lock;

`ifdef MEMARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (others[i] && (win == '0)) win[i] = 1'b1;
        end
    end
`else
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
    int            rr_idx;

    always_comb begin
        win    = '0;
        rr_idx = 0;
        for (int off = 0; off < NREQ; off++) begin
            rr_idx = (int'(rr_ptr_reg) + off) % NREQ;
            if (others[rr_idx] && (win == '0)) win[rr_idx] = 1'b1;
        end
    end

    // Any change to a non-zero grant is a new grant; the pointer moves past the winner.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if ((gnt_next != '0) && (gnt_next != gnt_reg)) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_next[i]) rr_ptr_next = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_next      = win;
                    hold_cnt_next = '0;
                    state_next    = OWNED;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    hold_cnt_next = '0;
                    if (|others) begin
                        gnt_next = win;
                    end else begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (|others) begin
                    if (preempt_ok) begin
                        gnt_next      = win;
                        hold_cnt_next = '0;
                    end else if (hold_cnt_reg != HOLD_LIMIT) begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
                end else begin
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                gnt_next      = '0;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // AND-OR mux keyed by the registered grant: no grant yields all-zero outputs.
    logic [31:0] addr_sel [NREQ];
    logic [31:0] offs_sel [NREQ];
    logic [31:0] data_sel [NREQ];
    logic [2:0]  mode_sel [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mux
            assign addr_sel[gi] = gnt_reg[gi] ? req_address[32*gi +: 32] : 32'd0;
            assign offs_sel[gi] = gnt_reg[gi] ? req_offset[32*gi +: 32]  : 32'd0;
            assign data_sel[gi] = gnt_reg[gi] ? req_data[32*gi +: 32]    : 32'd0;
            assign mode_sel[gi] = gnt_reg[gi] ? req_mode[3*gi +: 3]      : 3'd0;
        end
    endgenerate

    always_comb begin
        mem_address = '0;
        mem_offset  = '0;
        mem_data    = '0;
        mem_mode    = '0;
        for (int i = 0; i < NREQ; i++) begin
            mem_address = mem_address | addr_sel[i];
            mem_offset  = mem_offset  | offs_sel[i];
            mem_data    = mem_data    | data_sel[i];
            mem_mode    = mem_mode    | mode_sel[i];
        end
    end

    assign gnt  = gnt_reg;
    assign busy = |gnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and a
// randomized run against an owner/pointer reference model.
module tb_mem_port_arbiter;
    localparam int NREQ = 3;
    localparam int MAXH = 4;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] lock;
        logic [NREQ-1:0] gnt;
    } vec_t;

    logic                clk = 1'b0;
    logic                init_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     lock = '0;
    logic [32*NREQ-1:0]  req_address = '0;
    logic [32*NREQ-1:0]  req_offset = '0;
    logic [32*NREQ-1:0]  req_data = '0;
    logic [3*NREQ-1:0]   req_mode = '0;
    logic [NREQ-1:0]     gnt;
    logic [31:0]         mem_address, mem_offset, mem_data;
    logic [2:0]          mem_mode;
    logic                busy;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner index (-1 = none) and contended-cycle count.
    int m_owner = -1;
    int m_hold  = 0;
`ifndef MEMARB_FIXED_PRIO_EN
    int m_rr    = 0;
`endif

    mem_port_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .init_n(init_n), .req(req), .lock(lock),
        .req_address(req_address), .req_offset(req_offset), .req_data(req_data),
        .req_mode(req_mode), .gnt(gnt), .mem_address(mem_address),
        .mem_offset(mem_offset), .mem_data(mem_data), .mem_mode(mem_mode), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(logic [NREQ-1:0] r, int excl);
`ifdef MEMARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && i != excl) return i;
        end
`else
        int c;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_rr + k) % NREQ;
            if (r[c] && c != excl) return c;
        end
`endif
        return -1;
    endfunction

    function automatic void model_grant(int w);
        m_owner = w;
        m_hold  = 0;
`ifndef MEMARB_FIXED_PRIO_EN
        m_rr = (w + 1) % NREQ;
`endif
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_hold  = 0;
`ifndef MEMARB_FIXED_PRIO_EN
        m_rr = 0;
`endif
    endfunction

    function automatic void model_step(logic [NREQ-1:0] r, logic [NREQ-1:0] l);
        int w;
        logic [NREQ-1:0] rest;
        if (m_owner < 0) begin
            w = model_pick(r, -1);
            if (w >= 0) model_grant(w);
        end else if (!r[m_owner]) begin
            w = model_pick(r, m_owner);
            if (w >= 0) model_grant(w);
            else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else begin
            rest = r;
            rest[m_owner] = 1'b0;
            if (rest == '0) m_hold = 0;
            else if (m_hold == MAXH - 1 && !l[m_owner]) model_grant(model_pick(r, m_owner));
            else if (m_hold < MAXH - 1) m_hold++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [NREQ-1:0] eg;
        logic [31:0] ea, eo, ed;
        logic [2:0] em;
        eg = '0; ea = '0; eo = '0; ed = '0; em = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ea = req_address[32*m_owner +: 32];
            eo = req_offset[32*m_owner +: 32];
            ed = req_data[32*m_owner +: 32];
            em = req_mode[3*m_owner +: 3];
        end
        chk({tag, " gnt"},  32'(gnt), 32'(eg));
        chk({tag, " busy"}, 32'(busy), 32'(eg != '0));
        chk({tag, " addr"}, mem_address, ea);
        chk({tag, " offs"}, mem_offset, eo);
        chk({tag, " data"}, mem_data, ed);
        chk({tag, " mode"}, 32'(mem_mode), 32'(em));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < NREQ; i++) begin
            req_address[32*i +: 32] = 32'h1000_0000 + 32'(i * 16);
            req_offset[32*i +: 32]  = 32'h2000_0000 + 32'(i);
            req_data[32*i +: 32]    = 32'hA000_0000 + 32'(i);
            req_mode[3*i +: 3]      = 3'(i + 1);
        end
    endtask

    task automatic do_reset();
        req = '0;
        lock = '0;
        @(negedge clk);
        init_n = 1'b0;
        #2;
        init_n = 1'b1;
        model_reset();
    endtask

    vec_t tbl [13];

    initial begin
        int n;
        int bad;
        logic [31:0] ea;
        logic [2:0]  em;

`ifdef MEMARB_FIXED_PRIO_EN
        tbl[0]  = '{3'b111, 3'b000, 3'b001};
        tbl[1]  = '{3'b110, 3'b000, 3'b010};
        tbl[2]  = '{3'b101, 3'b000, 3'b001};
        tbl[3]  = '{3'b011, 3'b000, 3'b001};
        tbl[4]  = '{3'b001, 3'b000, 3'b001};
        tbl[5]  = '{3'b100, 3'b000, 3'b100};
        tbl[6]  = '{3'b000, 3'b000, 3'b000};
        tbl[7]  = '{3'b110, 3'b000, 3'b010};
        tbl[8]  = '{3'b000, 3'b000, 3'b000};
        tbl[9]  = '{3'b011, 3'b000, 3'b001};
        tbl[10] = '{3'b000, 3'b000, 3'b000};
        tbl[11] = '{3'b100, 3'b000, 3'b100};
        tbl[12] = '{3'b000, 3'b000, 3'b000};
`else
        tbl[0]  = '{3'b111, 3'b000, 3'b001};
        tbl[1]  = '{3'b110, 3'b000, 3'b010};
        tbl[2]  = '{3'b101, 3'b000, 3'b100};
        tbl[3]  = '{3'b011, 3'b000, 3'b001};
        tbl[4]  = '{3'b001, 3'b000, 3'b001};
        tbl[5]  = '{3'b100, 3'b000, 3'b100};
        tbl[6]  = '{3'b000, 3'b000, 3'b000};
        tbl[7]  = '{3'b000, 3'b000, 3'b000};
        tbl[8]  = '{3'b010, 3'b000, 3'b010};
        tbl[9]  = '{3'b011, 3'b000, 3'b010};
        tbl[10] = '{3'b110, 3'b000, 3'b010};
        tbl[11] = '{3'b100, 3'b000, 3'b100};
        tbl[12] = '{3'b000, 3'b000, 3'b000};
`endif

        set_defaults();
        do_reset();
        #1;
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mode", 32'(mem_mode), 32'd0);
        chk("reset addr", mem_address, 32'd0);
        chk("reset data", mem_data, 32'd0);
        $display("reset: gnt=%b mode=%b", gnt, mem_mode);

        for (int v = 0; v < 13; v++) begin
            req  = tbl[v].req;
            lock = tbl[v].lock;
            tick();
            ea = '0;
            em = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (tbl[v].gnt[i]) begin
                    ea = req_address[32*i +: 32];
                    em = req_mode[3*i +: 3];
                end
            end
            chk($sformatf("vec%0d gnt", v), 32'(gnt), 32'(tbl[v].gnt));
            chk($sformatf("vec%0d addr", v), mem_address, ea);
            chk($sformatf("vec%0d mode", v), 32'(mem_mode), 32'(em));
            $display("vec%0d: req=%b gnt=%b addr=%h", v, req, gnt, mem_address);
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 3'b010;
        req_mode[3 +: 3] = 3'b001;
        tick();
        chk("midreset pre gnt", 32'(gnt), 32'b010);
        #2;
        init_n = 1'b0;
        #1;
        chk("midreset gnt", 32'(gnt), 32'd0);
        chk("midreset mode", 32'(mem_mode), 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        tick();
        chk("midreset regrant", 32'(gnt), 32'b010);
        $display("midreset: gnt=%b after release", gnt);
        set_defaults();

        // Preemption of an unlocked owner after MAXH contended cycles.
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b011;
        n = 0;
        while (gnt !== 3'b001 && n < 20) begin
            tick();
            n++;
        end
        chk("preempt cycles", 32'(n), 32'd4);
        chk("preempt gnt", 32'(gnt), 32'b001);
        $display("preempt: moved after %0d contended cycles", n);

        // Lock blocks preemption; releasing lock with saturated count preempts at once.
        do_reset();
        req = 3'b010;
        lock = 3'b010;
        tick();
        req = 3'b011;
        bad = 0;
        repeat (50) begin
            tick();
            if (gnt !== 3'b010) bad++;
        end
        chk("lock hold", 32'(bad), 32'd0);
        lock = 3'b000;
        tick();
        chk("unlock preempt", 32'(gnt), 32'b001);
        $display("lock: %0d bad cycles, gnt=%b after unlock", bad, gnt);

        // Non-owner mode/data must not reach the memory port.
        do_reset();
        req = 3'b010;
        req_mode[0 +: 3] = 3'b001;
        req_data[0 +: 32] = 32'hDEADBEEF;
        req_mode[3 +: 3] = 3'b110;
        tick();
        req = 3'b011;
        #1;
        chk("mask mode", 32'(mem_mode), 32'b110);
        chk("mask data", mem_data, 32'hA000_0001);
        $display("mask: mode=%b data=%h", mem_mode, mem_data);
        set_defaults();

        // Randomized run against the reference model.
        do_reset();
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(3) == 0) req[i] = ~req[i];
                lock[i] = ($urandom_range(7) == 0);
                req_address[32*i +: 32] = $urandom;
                req_offset[32*i +: 32]  = $urandom;
                req_data[32*i +: 32]    = $urandom;
                req_mode[3*i +: 3]      = 3'($urandom_range(7));
            end
            model_step(req, lock);
            tick();
            chk_model($sformatf("rnd%0d", t));
            $display("rnd%0d: req=%b lock=%b gnt=%b mode=%b", t, req, lock, gnt, mem_mode);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
